// File: rtl/exec_seq.sv
// exec_seq: multi-cycle sequencer for RV32I OP / OP-IMM instructions over a
// shared register-file bus.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   instr_valid  upstream offers instr this cycle
//   instr        RV32I instruction word (only sampled at acceptance)
//   instr_ready  high only in IDLE
//   bus          shared 32-bit data bus; driven by this block only in WB
//   reg_idx      register file index (rs1 / rs2 / rd, else 0)
//   reg_en       register file drives bus (RS1 / RS2)
//   reg_write    register file captures bus at regs[reg_idx] (WB)
//   done         high during the WB cycle
//   illegal      one-cycle pulse after a rejected instruction
//   dbg_state    current FSM state, for checkers
//
// Handshake: an instruction transfers on a rising edge where
// instr_valid && instr_ready; after that the instr input is ignored until the
// block is back in IDLE.  A rejected word also transfers (and is dropped).
module exec_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  inout  wire  [31:0] bus,
  output logic [4:0]  reg_idx,
  output logic        reg_en,
  output logic        reg_write,
  output logic        done,
  output logic        illegal,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RS1  = 2'd1,
    S_RS2  = 2'd2,
    S_WB   = 2'd3
  } state_t;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  state_t      state_q;
  logic [31:0] instr_q;
  logic [31:0] op_a_q;
  logic [31:0] op_b_q;
  logic [4:0]  reg_idx_q;
  logic        reg_en_q;
  logic        reg_write_q;
  logic        done_q;
  logic        illegal_q;
  logic        drive_q;

  // Legality of the word currently offered on instr.
  logic       in_legal_d;
  logic [6:0] in_f7;
  logic [2:0] in_f3;

  always_comb begin
    in_f7      = instr[31:25];
    in_f3      = instr[14:12];
    in_legal_d = 1'b0;
    if (instr[6:0] == OPC_OP) begin
      in_legal_d = (in_f7 == 7'd0) ||
                   ((in_f7 == F7_ALT) && ((in_f3 == 3'b000) || (in_f3 == 3'b101)));
    end else if (instr[6:0] == OPC_OPIMM) begin
      case (in_f3)
        3'b001:  in_legal_d = (in_f7 == 7'd0);
        3'b101:  in_legal_d = (in_f7 == 7'd0) || (in_f7 == F7_ALT);
        default: in_legal_d = 1'b1;
      endcase
    end
  end

  // ALU on the latched operands; only observed on the bus during WB.
  logic        q_is_op;
  logic [31:0] result_d;

  always_comb begin
    q_is_op  = (instr_q[6:0] == OPC_OP);
    result_d = '0;
    case (instr_q[14:12])
      3'b000: result_d = (q_is_op && instr_q[30]) ? (op_a_q - op_b_q) : (op_a_q + op_b_q);
      3'b001: result_d = op_a_q << op_b_q[4:0];
      3'b010: result_d = {31'd0, ($signed(op_a_q) < $signed(op_b_q))};
      3'b011: result_d = {31'd0, (op_a_q < op_b_q)};
      3'b100: result_d = op_a_q ^ op_b_q;
      3'b101: result_d = instr_q[30] ? $unsigned($signed(op_a_q) >>> op_b_q[4:0])
                                     : (op_a_q >> op_b_q[4:0]);
      3'b110: result_d = op_a_q | op_b_q;
      3'b111: result_d = op_a_q & op_b_q;
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      instr_q     <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      reg_idx_q   <= '0;
      reg_en_q    <= 1'b0;
      reg_write_q <= 1'b0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
      drive_q     <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            if (in_legal_d) begin
              instr_q   <= instr;
              // Immediate operand for OP-IMM; OP overwrites it in RS2.
              op_b_q    <= {{20{instr[31]}}, instr[31:20]};
              state_q   <= S_RS1;
              reg_idx_q <= instr[19:15];
              reg_en_q  <= 1'b1;
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        S_RS1: begin
          op_a_q <= bus;
          if (q_is_op) begin
            state_q   <= S_RS2;
            reg_idx_q <= instr_q[24:20];
          end else begin
            state_q     <= S_WB;
            reg_idx_q   <= instr_q[11:7];
            reg_en_q    <= 1'b0;
            reg_write_q <= 1'b1;
            done_q      <= 1'b1;
            drive_q     <= 1'b1;
          end
        end
        S_RS2: begin
          op_b_q      <= bus;
          state_q     <= S_WB;
          reg_idx_q   <= instr_q[11:7];
          reg_en_q    <= 1'b0;
          reg_write_q <= 1'b1;
          done_q      <= 1'b1;
          drive_q     <= 1'b1;
        end
        S_WB: begin
          state_q     <= S_IDLE;
          reg_idx_q   <= '0;
          reg_write_q <= 1'b0;
          done_q      <= 1'b0;
          drive_q     <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // drive_q is set only on entry to WB, where reg_en_q is cleared, so the
  // two bus drivers are never enabled together.
  assign bus         = drive_q ? result_d : 32'hzzzz_zzzz;
  assign instr_ready = (state_q == S_IDLE);
  assign reg_idx     = reg_idx_q;
  assign reg_en      = reg_en_q;
  assign reg_write   = reg_write_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/exec_seq.md
EXEC_SEQ -- requirements
Module: exec_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-002 SHALL have port rst, input, 1 bit, reset: synchronous, active-high.
REQ-003 SHALL have port instr_valid, input, 1 bit, upstream offers instr this cycle.
REQ-004 SHALL have port instr, input, 32 bits, RV32I instruction word.
REQ-005 SHALL have port instr_ready, output, 1 bit, high only in IDLE.
REQ-006 SHALL have port bus, inout, 32 bits, shared data bus to the register file.
REQ-007 SHALL have port reg_idx, output, 5 bits, register file index.
REQ-008 SHALL have port reg_en, output, 1 bit, register file drives bus when high.
REQ-009 SHALL have port reg_write, output, 1 bit, register file captures bus at regs[reg_idx] at clock edge.
REQ-010 SHALL have port done, output, 1 bit, high during the WB cycle.
REQ-011 SHALL have port illegal, output, 1 bit, one-cycle pulse on a rejected instruction.

Function
REQ-012 SHALL implement states IDLE, RS1, RS2, WB.
REQ-013 Handshake: an instruction SHALL be accepted when instr_valid && instr_ready at a rising edge; instr is latched internally and ignored afterwards.
REQ-014 Accepted opcode 0110011 (OP) SHALL go IDLE->RS1->RS2->WB->IDLE.
REQ-015 Accepted opcode 0010011 (OP-IMM) SHALL go IDLE->RS1->WB->IDLE.
REQ-016 Any other opcode SHALL cause a stay in IDLE, with illegal=1 in the following cycle and no bus activity.
REQ-017 RS1: reg_idx=rs1, reg_en=1, reg_write=0; bus SHALL be latched into operand A at the edge.
REQ-018 RS2: reg_idx=rs2, reg_en=1, reg_write=0; bus SHALL be latched into operand B at the edge.
REQ-019 OP-IMM: operand B SHALL equal sign-extended instr[31:20].
REQ-020 WB: the block SHALL drive bus with the result; reg_idx=rd, reg_en=0, reg_write=1, done=1.
REQ-021 Outside WB the block SHALL drive bus with 'z.
REQ-022 reg_en and bus-drive SHALL never be high in the same cycle.
REQ-023 Outside RS1/RS2/WB: reg_idx=0, reg_en=0, reg_write=0.
REQ-024 funct3 decode SHALL be: 000 ADD (SUB if OP and instr[30]); 001 SLL; 010 SLT (signed); 011 SLTU; 100 XOR; 101 SRL (SRA if instr[30]); 110 OR; 111 AND.
REQ-025 Arithmetic SHALL be 32-bit, wrapping, carry discarded.
REQ-026 Shift amount SHALL be B[4:0]; SLT/SLTU results SHALL be 0 or 1.
REQ-027 OP with funct7 other than 0000000 SHALL be illegal, except 0100000 with funct3 000/101.
REQ-028 OP-IMM SLLI with instr[31:25]!=0 SHALL be illegal; SRLI/SRAI with instr[31:25] not 0000000/0100000 SHALL be illegal.
REQ-029 Illegal detection SHALL occur at acceptance: illegal pulse, no state change.
REQ-030 rd=0 SHALL still run WB normally; the register file discards the write.
REQ-031 Latency from the acceptance edge SHALL be: OP WB in cycle 3, OP-IMM WB in cycle 2.
REQ-032 Back-to-back instructions SHALL be accepted the cycle after WB.

Reset
REQ-033 rst=1 SHALL force IDLE at the next edge from any state, including mid-instruction; the pending instruction SHALL be dropped with no write.
REQ-034 While rst=1 or just after reset, outputs SHALL be: instr_ready=1 (in IDLE), reg_en=0, reg_write=0, reg_idx=0, done=0, illegal=0, bus='z.
REQ-035 Operand/instruction latches SHALL reset to 0.

Verification (bench includes register file, preloaded via writes)
REQ-036 x1=5, x2=7, ADD x3,x1,x2 -> RS1 idx1, RS2 idx2, WB idx3 bus=12; x3 reads 12.
REQ-037 x1=0x80000000, SRAI x4,x1,4 -> WB cycle 2, bus=0xF8000000; SUB x5,x0,x1 -> 0x80000000.
REQ-038 x1=0xFFFFFFFF, x2=1: SLT x6,x1,x2 -> 1; SLTU x7,x1,x2 -> 0; ADDI x8,x1,-1 -> 0xFFFFFFFE.
REQ-039 Instruction 0x00000073 (SYSTEM) -> illegal pulse, instr_ready stays 1, no reg_en/reg_write; OP with funct7=0000001 -> illegal.
REQ-040 rst asserted during RS2 of ADD x3 -> IDLE next cycle, no reg_write, x3 unchanged, bus 'z.
REQ-041 instr_valid held high with three ADDIs -> each accepted the cycle after the prior WB; bus never multiply driven (no X on bus).
